// File: rtl/anita3_buffer_scheduler.sv
// -----------------------------------------------------------------------------
// anita3_buffer_scheduler
//
// Trigger-to-digitize scheduler in the 125 MHz domain. Trigger requests from
// four sources are latched into a sticky pending mask. When a hold buffer is
// free, one is allocated round-robin. A fixed-width digitize pulse is then sent
// to the event generator together with the granted buffer and the source mask.
// Held buffers stay marked until readout releases them.
//
// Optional build macro: ANITA3_SCHED_DEADTIME_EN
//   When defined, this adds a saturating dead-time counter (deadtime_o) and
//   its clear input (deadtime_clr_i).
//
// Ports
//   clk125_i           in   sole clock, 125 MHz
//   rst_n_i            in   asynchronous active-low reset
//   enable_i           in   1 = accept requests, 0 = ignore and clear pending
//   trig_req_i[3:0]    in   request pulses (bit0 RF, bit1 PPS1, bit2 PPS2, bit3 SW)
//   clear_i            in   release buffer clear_buffer_i (strobe)
//   clear_buffer_i[1:0]in   buffer index for clear_i
//   clear_all_i        in   release all buffers and drop pending requests
//   deadtime_clr_i     in   (macro only) zero the dead-time counter
//   deadtime_o[15:0]   out  (macro only) clocks spent with requests blocked by full
//   digitize_o         out  digitize pulse to the event generator
//   digitize_buffer_o  out  granted buffer, held until the next grant
//   digitize_source_o  out  pending-source mask captured at grant
//   buffer_status_o    out  held-buffer mask
//   busy_o             out  FSM not idle
//   full_o             out  all four buffers held
//
// State table
//   state    | meaning
//   IDLE     | waiting for a pending request and a free buffer
//   DIGITIZE | digitize_o high, counting DIGITIZE_CYCLES clocks
//   HOLDOFF  | digitize_o low, counting HOLDOFF_CYCLES dead clocks
// -----------------------------------------------------------------------------
module anita3_buffer_scheduler #(
    parameter int DIGITIZE_CYCLES = 8,
    parameter int HOLDOFF_CYCLES  = 64
) (
    input  logic       clk125_i,
    input  logic       rst_n_i,
    input  logic       enable_i,
    input  logic [3:0] trig_req_i,
    input  logic       clear_i,
    input  logic [1:0] clear_buffer_i,
    input  logic       clear_all_i,
`ifdef ANITA3_SCHED_DEADTIME_EN
    input  logic        deadtime_clr_i,
    output logic [15:0] deadtime_o,
`endif
    output logic       digitize_o,
    output logic [1:0] digitize_buffer_o,
    output logic [3:0] digitize_source_o,
    output logic [3:0] buffer_status_o,
    output logic       busy_o,
    output logic       full_o
);

    localparam int CNT_MAX = (DIGITIZE_CYCLES > HOLDOFF_CYCLES) ? DIGITIZE_CYCLES : HOLDOFF_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIGITIZE = 2'd1,
        HOLDOFF  = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [3:0]         pending;
    logic [1:0]         rr_ptr;
    logic [1:0]         sel;
    logic [1:0]         idx;
    logic               sel_found;
    logic               grant;
    logic [3:0]         status_next;

    // Round-robin search for the first free buffer, starting at rr_ptr.
    always_comb begin
        sel       = 2'd0;
        sel_found = 1'b0;
        idx       = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = rr_ptr + 2'(i);
            if (!sel_found && !buffer_status_o[idx]) begin
                sel       = idx;
                sel_found = 1'b1;
            end
        end
    end

    assign grant = (state == IDLE) && (pending != 4'd0) && sel_found;

    // State register
    always_ff @(posedge clk125_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic. clear_all_i intentionally does not abort a pulse in flight.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_next = DIGITIZE;
                    cnt_next   = CNT_W'(DIGITIZE_CYCLES - 1);
                end
            end
            DIGITIZE: begin
                if (cnt == '0) begin
                    state_next = HOLDOFF;
                    cnt_next   = CNT_W'(HOLDOFF_CYCLES - 1);
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            HOLDOFF: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Output decode of registered state
    always_comb begin
        digitize_o = (state == DIGITIZE);
        busy_o     = (state != IDLE);
        full_o     = &buffer_status_o;
    end

    // Buffer status: clear_i first, then a grant set takes precedence over it,
    // and clear_all_i overrides everything.
    always_comb begin
        status_next = buffer_status_o;
        if (clear_i) begin
            status_next[clear_buffer_i] = 1'b0;
        end
        if (grant) begin
            status_next[sel] = 1'b1;
        end
        if (clear_all_i) begin
            status_next = 4'd0;
        end
    end

    always_ff @(posedge clk125_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            buffer_status_o   <= 4'd0;
            pending           <= 4'd0;
            rr_ptr            <= 2'd0;
            digitize_buffer_o <= 2'd0;
            digitize_source_o <= 4'd0;
        end else begin
            buffer_status_o <= status_next;

            // On a grant, the granted sources are consumed. A request that arrives
            // in the same cycle is kept for the next grant.
            if (!enable_i || clear_all_i) begin
                pending <= 4'd0;
            end else if (grant) begin
                pending <= trig_req_i;
            end else begin
                pending <= pending | trig_req_i;
            end

            if (grant) begin
                rr_ptr            <= sel + 2'd1;
                digitize_buffer_o <= sel;
                digitize_source_o <= pending;
            end
        end
    end

`ifdef ANITA3_SCHED_DEADTIME_EN
    always_ff @(posedge clk125_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            deadtime_o <= 16'd0;
        end else if (clear_all_i || deadtime_clr_i) begin
            deadtime_o <= 16'd0;
        end else if ((state == IDLE) && (pending != 4'd0) && full_o && (deadtime_o != 16'hFFFF)) begin
            deadtime_o <= deadtime_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_anita3_buffer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_anita3_buffer_scheduler
//
// Directed testbench. Stimulus pushes the expected pulse (buffer, source,
// status, rise cycle) into a queue. A monitor on the falling clock edge pops
// an entry on each digitize_o rise and checks it. The monitor also checks
// the pulse width and that buffer/source stay stable while the pulse is high.
// -----------------------------------------------------------------------------
module tb_anita3_buffer_scheduler;

    localparam int DIG  = 8;
    localparam int HOLD = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [3:0] trig_req;
    logic       clear;
    logic [1:0] clear_buffer;
    logic       clear_all;
    logic       digitize;
    logic [1:0] digitize_buffer;
    logic [3:0] digitize_source;
    logic [3:0] buffer_status;
    logic       busy;
    logic       full;
`ifdef ANITA3_SCHED_DEADTIME_EN
    logic        deadtime_clr;
    logic [15:0] deadtime;
`endif

    anita3_buffer_scheduler #(
        .DIGITIZE_CYCLES(DIG),
        .HOLDOFF_CYCLES (HOLD)
    ) dut (
        .clk125_i         (clk),
        .rst_n_i          (rst_n),
        .enable_i         (enable),
        .trig_req_i       (trig_req),
        .clear_i          (clear),
        .clear_buffer_i   (clear_buffer),
        .clear_all_i      (clear_all),
`ifdef ANITA3_SCHED_DEADTIME_EN
        .deadtime_clr_i   (deadtime_clr),
        .deadtime_o       (deadtime),
`endif
        .digitize_o       (digitize),
        .digitize_buffer_o(digitize_buffer),
        .digitize_source_o(digitize_source),
        .buffer_status_o  (buffer_status),
        .busy_o           (busy),
        .full_o           (full)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] bidx;
        logic [3:0] src;
        logic [3:0] status;
        int         rise;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input logic [1:0] b, input logic [3:0] s, input logic [3:0] st, input int rise);
        exp_t e;
        e.bidx   = b;
        e.src    = s;
        e.status = st;
        e.rise   = rise;
        sbq.push_back(e);
    endtask

    // Called at a falling edge: drives the request for one clock.
    task automatic drive_req(input logic [3:0] m);
        trig_req = m;
        @(negedge clk);
        trig_req = 4'd0;
    endtask

    // Monitor
    initial begin
        logic       prev;
        int         width;
        logic [1:0] cap_b;
        logic [3:0] cap_s;
        exp_t       e;
        prev  = 1'b0;
        width = 0;
        cap_b = 2'd0;
        cap_s = 4'd0;
        forever begin
            @(negedge clk);
            if (digitize && !prev) begin
                width = 1;
                cap_b = digitize_buffer;
                cap_s = digitize_source;
                if (sbq.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_pulse: got pulse buffer %0d source %0h expected none (cycle %0d)",
                             digitize_buffer, digitize_source, cyc);
                end else begin
                    e = sbq.pop_front();
                    check("grant_buffer", 32'(digitize_buffer), 32'(e.bidx));
                    check("grant_source", 32'(digitize_source), 32'(e.src));
                    check("grant_status", 32'(buffer_status), 32'(e.status));
                    check("grant_rise_cycle", 32'(cyc), 32'(e.rise));
                end
            end else if (digitize) begin
                width++;
                check("buffer_stable", 32'(digitize_buffer), 32'(cap_b));
                check("source_stable", 32'(digitize_source), 32'(cap_s));
            end else if (prev && rst_n) begin
                check("pulse_width", 32'(width), 32'(DIG));
            end
            prev = digitize;
        end
    end

    initial begin
        int c;
        rst_n        = 1'b0;
        enable       = 1'b0;
        trig_req     = 4'd0;
        clear        = 1'b0;
        clear_buffer = 2'd0;
        clear_all    = 1'b0;
`ifdef ANITA3_SCHED_DEADTIME_EN
        deadtime_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_digitize", 32'(digitize), 32'd0);
        check("rst_buffer", 32'(digitize_buffer), 32'd0);
        check("rst_source", 32'(digitize_source), 32'd0);
        check("rst_status", 32'(buffer_status), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;

        // Four RF triggers fill buffers 0..3 in order.
        for (int k = 0; k < 4; k++) begin
            push(2'(k), 4'b0001, 4'((1 << (k + 1)) - 1), cyc + 2);
            drive_req(4'b0001);
            repeat (99) @(negedge clk);
            check("busy_after_grant", 32'(busy), 32'd0);
        end
        check("status_full", 32'(buffer_status), 32'hF);
        check("full_flag", 32'(full), 32'd1);

        // Fifth request: no free buffer, stays pending.
        drive_req(4'b0001);
        repeat (100) @(negedge clk);
        check("dead_busy", 32'(busy), 32'd0);
        check("dead_full", 32'(full), 32'd1);

        // Releasing buffer 2 lets the pending RF request take it one clock later.
        push(2'd2, 4'b0001, 4'hF, cyc + 2);
        clear        = 1'b1;
        clear_buffer = 2'd2;
        @(negedge clk);
        clear = 1'b0;
        check("status_after_clear", 32'(buffer_status), 32'hB);
        repeat (99) @(negedge clk);
        check("status_refilled", 32'(buffer_status), 32'hF);

        // Release all buffers. rr_ptr is now 3.
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        check("status_clear_all", 32'(buffer_status), 32'h0);

        // Two sources in one pulse. A request during DIGITIZE is granted right after HOLDOFF.
        c = cyc;
        push(2'd3, 4'b0101, 4'b1000, c + 2);
        drive_req(4'b0101);
        repeat (3) @(negedge clk);
        push(2'd0, 4'b0010, 4'b1001, c + 2 + DIG + HOLD + 1);
        drive_req(4'b0010);
        repeat (160) @(negedge clk);
        check("status_t4", 32'(buffer_status), 32'b1001);

        // clear_all in the middle of DIGITIZE: the pulse still completes, and
        // a request latched just before the clear is dropped.
        c = cyc;
        push(2'd1, 4'b0001, 4'b1011, c + 2);
        drive_req(4'b0001);
        repeat (2) @(negedge clk);
        drive_req(4'b0100);
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        check("clear_all_mid_status", 32'(buffer_status), 32'h0);
        check("clear_all_mid_digitize", 32'(digitize), 32'd1);
        repeat (150) @(negedge clk);
        check("after_clear_all_status", 32'(buffer_status), 32'h0);
        check("after_clear_all_busy", 32'(busy), 32'd0);

        // An asynchronous reset mid-pulse drops digitize_o immediately.
        c = cyc;
        push(2'd2, 4'b1000, 4'b0100, c + 2);
        drive_req(4'b1000);
        repeat (3) @(negedge clk);
        check("pre_reset_digitize", 32'(digitize), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_digitize", 32'(digitize), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_status", 32'(buffer_status), 32'd0);
        check("async_rst_buffer", 32'(digitize_buffer), 32'd0);
        check("async_rst_source", 32'(digitize_source), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef ANITA3_SCHED_DEADTIME_EN
        for (int k = 0; k < 4; k++) begin
            push(2'(k), 4'b0001, 4'((1 << (k + 1)) - 1), cyc + 2);
            drive_req(4'b0001);
            repeat (79) @(negedge clk);
        end
        deadtime_clr = 1'b1;
        @(negedge clk);
        deadtime_clr = 1'b0;
        check("deadtime_zero", 32'(deadtime), 32'd0);
        trig_req = 4'b0001;
        @(negedge clk);
        trig_req = 4'd0;
        repeat (999) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        check("deadtime_1000", 32'(deadtime), 32'd1000);
        deadtime_clr = 1'b1;
        @(negedge clk);
        deadtime_clr = 1'b0;
        check("deadtime_cleared", 32'(deadtime), 32'd0);
        trig_req = 4'b0001;
        @(negedge clk);
        trig_req = 4'd0;
        repeat (70000) @(negedge clk);
        check("deadtime_saturate", 32'(deadtime), 32'hFFFF);
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        check("deadtime_clear_all", 32'(deadtime), 32'd0);
        check("deadtime_status", 32'(buffer_status), 32'd0);
`endif

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
